// File: rtl/pwm_av_led_seq_pkg.sv
// Shared definitions for the LED sequencer: register offsets, CTRL bit
// positions, FSM state encoding and LED width.
package pwm_av_led_seq_pkg;

    localparam int LED_W = 8;

    localparam logic [3:0] REG_CTRL   = 4'd0;
    localparam logic [3:0] REG_PERIOD = 4'd1;
    localparam logic [3:0] REG_LENGTH = 4'd2;
    localparam logic [3:0] REG_DIRECT = 4'd3;
    localparam logic [3:0] REG_STEP   = 4'd4;

    // CTRL write bits
    localparam int CTRL_RUN      = 0;
    localparam int CTRL_LOOP     = 1;
    localparam int CTRL_DONE_CLR = 2;
    localparam int CTRL_IRQ_EN   = 4;
    // CTRL read-only bits
    localparam int CTRL_BUSY     = 2;
    localparam int CTRL_DONE     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIR_WR = 2'd1,
        SEQ_WR = 2'd2,
        HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/pwm_av_led_seq_timer.sv
// Step-period down-counter.
// Ports: clk, reset (async, active-high), load/load_val (load count),
//        en (decrement while non-zero), zero (count == 0).
module pwm_av_led_seq_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PERIOD_W-1:0] load_val,
    input  logic                en,
    output logic                zero
);

    logic [PERIOD_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pwm_av_led_sequencer.sv
// Avalon-MM LED sequencer: CPU-facing register file and pattern RAM, FSM
// that replays patterns as single-cycle writes to the LED PIO, and
// arbitration of one-shot direct LED writes against the sequence.
// Ports: clk, reset (async, active-high);
//        slave: address, chipselect, write_n, writedata, readdata, irq;
//        master: pio_address, pio_chipselect, pio_write_n, pio_writedata.
//
// state  | meaning
// IDLE   | waiting for a pending direct write or run
// DIR_WR | one master write of the pending direct value
// SEQ_WR | one master write of PAT[step], timer loaded
// HOLD   | timer counting the step period
module pwm_av_led_sequencer
    import pwm_av_led_seq_pkg::*;
#(
    parameter int PERIOD_W = 24,
    parameter int DEPTH    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata
);

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    state_t              state, state_nx;
    logic [2:0]          step, step_nx;
    logic                run, loop, irq_en, done, pend;
    logic [PERIOD_W-1:0] period;
    logic [2:0]          length;
    logic [LED_W-1:0]    pend_val;
    logic [LED_W-1:0]    led;
    logic [LED_W-1:0]    pat [DEPTH];

    logic                wr, ctrl_wr, pat_hit;
    logic                hw_done_set, pend_clr, timer_load, timer_zero;
    logic [PERIOD_W-1:0] timer_val;
    logic                unused_wd;

    assign wr        = chipselect & ~write_n;
    assign ctrl_wr   = wr && (address == REG_CTRL);
    assign pat_hit   = address[3] && ({1'b0, address[2:0]} < DEPTH_L);
    assign unused_wd = ^writedata;

    // A zero period behaves as one clock per step.
    assign timer_val = (period == '0) ? '0 : period - 1'b1;

    pwm_av_led_seq_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (state == HOLD),
        .zero     (timer_zero)
    );

    always_comb begin
        state_nx    = state;
        step_nx     = step;
        hw_done_set = 1'b0;
        pend_clr    = 1'b0;
        timer_load  = 1'b0;
        case (state)
            IDLE: begin
                if (pend) begin
                    pend_clr = 1'b1;
                    state_nx = DIR_WR;
                end else if (run) begin
                    step_nx  = 3'd0;
                    state_nx = SEQ_WR;
                end
            end
            DIR_WR: state_nx = IDLE;
            SEQ_WR: begin
                timer_load = 1'b1;
                state_nx   = HOLD;
            end
            HOLD: begin
                if (!run) begin
                    state_nx = IDLE;
                end else if (timer_zero) begin
                    if (step < length) begin
                        step_nx  = step + 3'd1;
                        state_nx = SEQ_WR;
                    end else if (loop) begin
                        step_nx  = 3'd0;
                        state_nx = SEQ_WR;
                    end else begin
                        hw_done_set = 1'b1;
                        state_nx    = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // FSM, master-port outputs. The LED value is latched at the decision
    // so the write data is stable for the whole write cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            step           <= 3'd0;
            led            <= '0;
            pio_chipselect <= 1'b0;
        end else begin
            state          <= state_nx;
            step           <= step_nx;
            pio_chipselect <= (state_nx == DIR_WR) || (state_nx == SEQ_WR);
            if (state_nx == DIR_WR) begin
                led <= pend_val;
            end else if (state_nx == SEQ_WR) begin
                led <= pat[step_nx[IDX_W-1:0]];
            end
        end
    end

    // Register file. CPU writes to run win over the hardware clear; the
    // hardware done-set wins over a CPU clear; a DIRECT write wins over
    // the service clear of pend.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run      <= 1'b0;
            loop     <= 1'b0;
            irq_en   <= 1'b0;
            done     <= 1'b0;
            pend     <= 1'b0;
            period   <= '0;
            length   <= 3'd0;
            pend_val <= '0;
            for (int i = 0; i < DEPTH; i++) pat[i] <= '0;
        end else begin
            if (ctrl_wr) begin
                run    <= writedata[CTRL_RUN];
                loop   <= writedata[CTRL_LOOP];
                irq_en <= writedata[CTRL_IRQ_EN];
            end else if (hw_done_set) begin
                run <= 1'b0;
            end

            if (hw_done_set) begin
                done <= 1'b1;
            end else if (ctrl_wr && writedata[CTRL_DONE_CLR]) begin
                done <= 1'b0;
            end

            if (wr && (address == REG_DIRECT)) begin
                pend     <= 1'b1;
                pend_val <= writedata[LED_W-1:0];
            end else if (pend_clr) begin
                pend <= 1'b0;
            end

            if (wr && (address == REG_PERIOD)) period <= writedata[PERIOD_W-1:0];
            if (wr && (address == REG_LENGTH)) length <= writedata[2:0];
            if (wr && pat_hit) pat[address[IDX_W-1:0]] <= writedata[LED_W-1:0];
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            REG_CTRL: begin
                readdata[CTRL_RUN]    = run;
                readdata[CTRL_LOOP]   = loop;
                readdata[CTRL_BUSY]   = (state != IDLE);
                readdata[CTRL_DONE]   = done;
                readdata[CTRL_IRQ_EN] = irq_en;
            end
            REG_PERIOD: readdata = 32'(period);
            REG_LENGTH: readdata = {29'b0, length};
            REG_DIRECT: readdata = 32'(pend_val);
            REG_STEP:   readdata = {29'b0, step};
            default: begin
                if (pat_hit) readdata = 32'(pat[address[IDX_W-1:0]]);
            end
        endcase
    end

    assign irq           = done & irq_en;
    assign pio_address   = 2'b00;
    assign pio_write_n   = ~pio_chipselect;
    assign pio_writedata = {{(32-LED_W){1'b0}}, led};

endmodule
